// File: rtl/branch_pkg.sv
// Types shared by the branch update queue and its entry storage.
package branch_pkg;

    localparam int BR_PC_NBITS = 32;

    typedef struct packed {
        logic                   taken;
        logic [BR_PC_NBITS-1:0] pc;
    } br_entry_t;

    // True when the queued prediction disagrees with the resolved direction.
    function automatic logic br_mispredict(input br_entry_t entry, input logic actual);
        return entry.taken != actual;
    endfunction

endpackage

// File: rtl/branch_update_queue_storage.sv
// Entry array for the branch update queue: one write port, one combinational read port.
module branch_update_queue_storage
    import branch_pkg::*;
#(
    parameter int num_entries = 8,
    localparam int AW = $clog2(num_entries)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  br_entry_t     wdata_i,
    input  logic [AW-1:0] raddr_i,
    output br_entry_t     rdata_o
);

    br_entry_t mem_q [num_entries];

    // Synchronous write; contents are not reset because occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of branch predictions; drives predictor updates on resolve and flushes on mispredict.
module branch_update_queue
    import branch_pkg::*;
#(
    parameter int num_entries = 8,
    parameter int cnt_nbits   = 32,
    localparam int PTR_W = $clog2(num_entries),
    localparam int OCC_W = $clog2(num_entries + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pred_val,
    output logic                   pred_rdy,
    input  logic                   pred_taken,
    input  logic [BR_PC_NBITS-1:0] pred_pc,
    input  logic                   resolve_val,
    output logic                   resolve_rdy,
    input  logic                   resolve_taken,
    output logic                   update_en,
    output logic                   update_val,
    output logic [BR_PC_NBITS-1:0] update_pc,
    output logic                   mispredict,
    output logic [cnt_nbits-1:0]   num_branches,
    output logic [cnt_nbits-1:0]   num_mispredicts,
    output logic [OCC_W-1:0]       occupancy
);

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   update_en_q, update_en_d;
    logic                   update_val_q, update_val_d;
    logic [BR_PC_NBITS-1:0] update_pc_q, update_pc_d;
    logic                   mispredict_q, mispredict_d;
    logic [cnt_nbits-1:0]   nbr_q, nbr_d;
    logic [cnt_nbits-1:0]   nmis_q, nmis_d;

    logic      enq_fire_s;
    logic      res_fire_s;
    logic      mis_s;
    logic      wr_en_s;
    br_entry_t wr_entry_s;
    br_entry_t head_entry_s;

    branch_update_queue_storage #(
        .num_entries(num_entries)
    ) u_storage (
        .clk     (clk),
        .we_i    (wr_en_s),
        .waddr_i (tail_q),
        .wdata_i (wr_entry_s),
        .raddr_i (head_q),
        .rdata_o (head_entry_s)
    );

    assign pred_rdy    = (occ_q != OCC_W'(num_entries));
    assign resolve_rdy = (occ_q != {OCC_W{1'b0}});

    // Handshake decode; a mispredicting resolve turns any same-cycle enqueue into a dropped wrong-path entry.
    always_comb begin
        enq_fire_s       = pred_val && pred_rdy;
        res_fire_s       = resolve_val && resolve_rdy;
        mis_s            = res_fire_s && br_mispredict(head_entry_s, resolve_taken);
        wr_en_s          = enq_fire_s && !mis_s;
        wr_entry_s.taken = pred_taken;
        wr_entry_s.pc    = pred_pc;
    end

    // Pointer and occupancy next state, including the flush that empties the queue behind the resolved head.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (res_fire_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        if (mis_s) begin
            tail_d = head_q + PTR_W'(1);
            occ_d  = {OCC_W{1'b0}};
        end else if (enq_fire_s) begin
            tail_d = tail_q + PTR_W'(1);
            occ_d  = occ_q + OCC_W'(1) - OCC_W'(res_fire_s);
        end else begin
            tail_d = tail_q;
            occ_d  = occ_q - OCC_W'(res_fire_s);
        end
    end

    // Update pulse and saturating statistics; update_val/update_pc hold between resolves.
    always_comb begin
        update_en_d  = res_fire_s;
        mispredict_d = mis_s;
        update_val_d = update_val_q;
        update_pc_d  = update_pc_q;
        nbr_d        = nbr_q;
        nmis_d       = nmis_q;
        if (res_fire_s) begin
            update_val_d = resolve_taken;
            update_pc_d  = head_entry_s.pc;
        end else begin
            update_val_d = update_val_q;
            update_pc_d  = update_pc_q;
        end
        if (res_fire_s && (nbr_q != {cnt_nbits{1'b1}})) begin
            nbr_d = nbr_q + cnt_nbits'(1);
        end else begin
            nbr_d = nbr_q;
        end
        if (mis_s && (nmis_q != {cnt_nbits{1'b1}})) begin
            nmis_d = nmis_q + cnt_nbits'(1);
        end else begin
            nmis_d = nmis_q;
        end
    end

    // State registers with synchronous reset; reset overrides a resolve from the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= {PTR_W{1'b0}};
            tail_q       <= {PTR_W{1'b0}};
            occ_q        <= {OCC_W{1'b0}};
            update_en_q  <= 1'b0;
            update_val_q <= 1'b0;
            update_pc_q  <= {BR_PC_NBITS{1'b0}};
            mispredict_q <= 1'b0;
            nbr_q        <= {cnt_nbits{1'b0}};
            nmis_q       <= {cnt_nbits{1'b0}};
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            update_en_q  <= update_en_d;
            update_val_q <= update_val_d;
            update_pc_q  <= update_pc_d;
            mispredict_q <= mispredict_d;
            nbr_q        <= nbr_d;
            nmis_q       <= nmis_d;
        end
    end

    assign update_en       = update_en_q;
    assign update_val      = update_val_q;
    assign update_pc       = update_pc_q;
    assign mispredict      = mispredict_q;
    assign num_branches    = nbr_q;
    assign num_mispredicts = nmis_q;
    assign occupancy       = occ_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench: a queue-based model predicts each update; a monitor checks the DUT outputs as they appear.
module tb_branch_update_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_val, pred_taken, resolve_val, resolve_taken;
    logic [31:0] pred_pc;

    logic        pred_rdy, resolve_rdy, update_en, update_val, mispredict;
    logic [31:0] update_pc, num_branches, num_mispredicts;
    logic [3:0]  occupancy;

    logic        pred_rdy2, resolve_rdy2, update_en2, update_val2, mispredict2;
    logic [31:0] update_pc2;
    logic [3:0]  num_branches2, num_mispredicts2;
    logic [3:0]  occupancy2;

    always #5 clk = ~clk;

    branch_update_queue #(.num_entries(8), .cnt_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .pred_val(pred_val), .pred_rdy(pred_rdy), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .resolve_val(resolve_val), .resolve_rdy(resolve_rdy), .resolve_taken(resolve_taken),
        .update_en(update_en), .update_val(update_val), .update_pc(update_pc),
        .mispredict(mispredict), .num_branches(num_branches),
        .num_mispredicts(num_mispredicts), .occupancy(occupancy)
    );

    // Same stimulus with narrow counters to exercise saturation.
    branch_update_queue #(.num_entries(8), .cnt_nbits(4)) dut_sat (
        .clk(clk), .reset(reset),
        .pred_val(pred_val), .pred_rdy(pred_rdy2), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .resolve_val(resolve_val), .resolve_rdy(resolve_rdy2), .resolve_taken(resolve_taken),
        .update_en(update_en2), .update_val(update_val2), .update_pc(update_pc2),
        .mispredict(mispredict2), .num_branches(num_branches2),
        .num_mispredicts(num_mispredicts2), .occupancy(occupancy2)
    );

    typedef struct {
        logic        taken;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        int          due;
        logic        val;
        logic [31:0] pc;
        logic        mis;
        int          nb;
        int          nm;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   model_nb = 0;
    int   model_nm = 0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] sat4(input int v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    // One cycle of stimulus: drive at negedge, check handshake state, advance the model.
    task automatic step(input logic pv, input logic pt, input logic [31:0] pc,
                        input logic rv, input logic rt);
        bit   e_fire, r_fire, mis;
        ent_t ent;
        exp_t e;
        @(negedge clk);
        reset         = 1'b0;
        pred_val      = pv;
        pred_taken    = pt;
        pred_pc       = pc;
        resolve_val   = rv;
        resolve_taken = rt;
        check("pred_rdy",    32'(pred_rdy),    32'(mq.size() != 8));
        check("resolve_rdy", 32'(resolve_rdy), 32'(mq.size() != 0));
        check("occupancy",   32'(occupancy),   32'(mq.size()));
        check("occupancy_sat", 32'(occupancy2), 32'(mq.size()));
        e_fire = pv && (mq.size() != 8);
        r_fire = rv && (mq.size() != 0);
        mis    = 1'b0;
        if (r_fire) begin
            ent = mq.pop_front();
            mis = (ent.taken != rt);
            model_nb++;
            if (mis) model_nm++;
            e.due = cyc + 1;
            e.val = rt;
            e.pc  = ent.pc;
            e.mis = mis;
            e.nb  = model_nb;
            e.nm  = model_nm;
            sb.push_back(e);
            if (mis) mq.delete();
        end
        if (e_fire && !mis) begin
            ent.taken = pt;
            ent.pc    = pc;
            mq.push_back(ent);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        pred_val    = 1'b0;
        resolve_val = 1'b0;
        sb.delete();
        mq.delete();
        model_nb = 0;
        model_nm = 0;
        @(posedge clk);
        #2;
        check("reset_update_en",  32'(update_en),  32'd0);
        check("reset_mispredict", 32'(mispredict), 32'd0);
        check("reset_occupancy",  32'(occupancy),  32'd0);
        check("reset_num_br",     num_branches,    32'd0);
        check("reset_num_mis",    num_mispredicts, 32'd0);
        check("reset_update_pc",  update_pc,       32'd0);
    endtask

    // Monitor: every update pulse must match the oldest outstanding expectation, on time.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (update_en === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_update_en", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("update_latency",  32'(cyc),        32'(e.due));
                    check("update_val",      32'(update_val), 32'(e.val));
                    check("update_pc",       update_pc,       e.pc);
                    check("mispredict",      32'(mispredict), 32'(e.mis));
                    check("num_branches",    num_branches,    32'(e.nb));
                    check("num_mispredicts", num_mispredicts, 32'(e.nm));
                    check("sat_update_pc",   update_pc2,      e.pc);
                    check("sat_num_br",      32'(num_branches2),    sat4(e.nb));
                    check("sat_num_mis",     32'(num_mispredicts2), sat4(e.nm));
                end
            end else begin
                if (mispredict !== 1'b0) check("mispredict_without_update", 32'(mispredict), 32'd0);
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    check("missing_update_en", 32'(update_en), 32'd1);
                end
            end
        end
    end

    initial begin
        logic rt;
        reset = 1'b1;
        pred_val = 1'b0; pred_taken = 1'b0; pred_pc = 32'd0;
        resolve_val = 1'b0; resolve_taken = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("idle_num_br", num_branches, 32'd0);

        // Correct prediction.
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Fill, refuse when full, drain in order, then wrap.
        for (int i = 0; i < 9; i++) step(1'b1, 1'(i), 32'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'(i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(32'h40 + i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Mispredict flush with a same-cycle enqueue that must be dropped.
        step(1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h14, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h18, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h1C, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Simultaneous enqueue/resolve at occupancy 4 and at full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(32'h200 + i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(32'h300 + i * 4), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(32'h400 + i * 4), 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h500, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic, mostly correct resolves so the queue builds up.
        for (int n = 0; n < 3000; n++) begin
            if (mq.size() != 0 && ($urandom % 8) != 0) rt = mq[0].taken;
            else rt = 1'($urandom);
            step(1'($urandom_range(0, 9) < 6), 1'($urandom), $urandom,
                 1'($urandom_range(0, 1)), rt);
        end

        // Reset the cycle after a resolve fire.
        step(1'b1, 1'b1, 32'h600, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
